// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer on the M-stage data bus: CTRL/PRESET/COUNT word
// registers, one-shot or auto-reload, registered interrupt request.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;
  logic        r_irq;

  logic        w_sel;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_auto;
  logic        w_expire;
  logic        w_flag_next;
  logic [3:0]  w_ctrl_next;
  logic        w_unused;

  assign w_sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr_ctrl   = write_enable && w_sel && (addr[3:2] == 2'd0);
  assign w_wr_preset = write_enable && w_sel && (addr[3:2] == 2'd1);
  assign w_auto      = (r_ctrl[2:1] == 2'b01);
  assign w_expire    = (r_state == ST_CNT) && r_ctrl[0] && (r_count <= 32'd1);
  assign w_unused    = &{1'b0, addr[1:0]};

  // Setting the flag on expiry beats a simultaneous CTRL-write clear.
  always_comb begin
    w_flag_next = r_irq_flag;
    if (w_expire)
      w_flag_next = 1'b1;
    else if (w_wr_ctrl || ((r_state == ST_INT) && w_auto))
      w_flag_next = 1'b0;
  end

  // One-shot expiry drops EN unless the bus writes CTRL on the same edge.
  always_comb begin
    w_ctrl_next = r_ctrl;
    if (w_wr_ctrl)
      w_ctrl_next = write_data[3:0];
    else if ((r_state == ST_INT) && !w_auto)
      w_ctrl_next = {r_ctrl[3:1], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ctrl     <= w_ctrl_next;
      r_irq_flag <= w_flag_next;
      r_irq      <= w_flag_next && w_ctrl_next[3];
      if (w_wr_preset)
        r_preset <= write_data;
      case (r_state)
        ST_IDLE: begin
          if (r_ctrl[0])
            r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= ST_IDLE;
          end else if (r_count <= 32'd1) begin
            r_count <= 32'd0;
            r_state <= ST_INT;
          end else begin
            r_count <= r_count - 32'd1;
          end
        end
        ST_INT: begin
          r_state <= w_auto ? ST_LOAD : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    read_result = 32'd0;
    case (addr[3:2])
      2'd0:    read_result = {28'd0, r_ctrl};
      2'd1:    read_result = r_preset;
      2'd2:    read_result = r_count;
      default: read_result = 32'd0;
    endcase
  end

  assign irq       = r_irq;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: one-shot, auto-reload, masking, pause,
// zero preset, reset mid-count and address decode.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic        irq;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_result  (read_result),
    .irq          (irq),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr         = a;
    write_data   = d;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    write_data   = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = read_result;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b0;
    addr         = 32'd0;
    write_enable = 1'b0;
    write_data   = 32'd0;

    // reset state
    #2;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    bus_read(A_CTRL, rd); chk("rst_ctrl", rd, 32'd0);

    // reset mid-count with COUNT=5
    bus_write(A_PRE, 32'd8);
    bus_write(A_CTRL, 32'h1);
    tick(); tick();
    tick(); tick(); tick();
    bus_read(A_CNT, rd); chk("pre_rst_cnt", rd, 32'd5);
    rst = 1'b0;
    #1;
    bus_read(A_CNT, rd);  chk("mid_rst_cnt", rd, 32'd0);
    bus_read(A_CTRL, rd); chk("mid_rst_ctrl", rd, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    tick();
    bus_read(A_CTRL, rd); chk("post_rst_ctrl", rd, 32'd0);
    bus_read(A_PRE, rd);  chk("post_rst_pre", rd, 32'd0);
    bus_read(A_CNT, rd);  chk("post_rst_cnt", rd, 32'd0);

    // one-shot, PRESET=3
    bus_write(A_PRE, 32'd3);
    bus_write(A_CTRL, 32'h9);
    tick();
    chk("os_e1_state", {30'd0, dbg_state}, 32'd1);
    tick();
    bus_read(A_CNT, rd); chk("os_e2_cnt", rd, 32'd3);
    tick();
    bus_read(A_CNT, rd); chk("os_e3_cnt", rd, 32'd2);
    tick();
    bus_read(A_CNT, rd); chk("os_e4_cnt", rd, 32'd1);
    chk("os_e4_irq", {31'd0, irq}, 32'd0);
    tick();
    bus_read(A_CNT, rd); chk("os_e5_cnt", rd, 32'd0);
    chk("os_e5_irq", {31'd0, irq}, 32'd1);
    chk("os_e5_state", {30'd0, dbg_state}, 32'd3);
    tick();
    bus_read(A_CTRL, rd); chk("os_e6_ctrl", rd, 32'h8);
    chk("os_e6_state", {30'd0, dbg_state}, 32'd0);
    tick(); tick(); tick();
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    bus_write(A_CTRL, 32'h0);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // auto-reload, PRESET=2: pulses every 4 cycles
    bus_write(A_PRE, 32'd2);
    bus_write(A_CTRL, 32'hB);
    tick(); tick();
    bus_read(A_CNT, rd); chk("ar_e2_cnt", rd, 32'd2);
    chk("ar_e2_irq", {31'd0, irq}, 32'd0);
    tick();
    bus_read(A_CNT, rd); chk("ar_e3_cnt", rd, 32'd1);
    tick();
    bus_read(A_CNT, rd); chk("ar_e4_cnt", rd, 32'd0);
    chk("ar_e4_irq", {31'd0, irq}, 32'd1);
    tick();
    chk("ar_e5_irq", {31'd0, irq}, 32'd0);
    chk("ar_e5_state", {30'd0, dbg_state}, 32'd1);
    tick();
    bus_read(A_CNT, rd); chk("ar_e6_cnt", rd, 32'd2);
    tick();
    bus_read(A_CNT, rd); chk("ar_e7_cnt", rd, 32'd1);
    chk("ar_e7_irq", {31'd0, irq}, 32'd0);
    tick();
    bus_read(A_CNT, rd); chk("ar_e8_cnt", rd, 32'd0);
    chk("ar_e8_irq", {31'd0, irq}, 32'd1);
    tick();
    chk("ar_e9_irq", {31'd0, irq}, 32'd0);
    bus_write(A_CTRL, 32'h0);
    tick(); tick();
    chk("ar_stop_state", {30'd0, dbg_state}, 32'd0);

    // mask: IM=0 never raises irq
    bus_write(A_PRE, 32'd1);
    bus_write(A_CTRL, 32'h1);
    tick(); tick(); tick();
    chk("mk_state_int", {30'd0, dbg_state}, 32'd3);
    chk("mk_irq_int", {31'd0, irq}, 32'd0);
    tick();
    bus_read(A_CTRL, rd); chk("mk_ctrl_en_clr", rd, 32'h0);
    bus_write(A_CTRL, 32'h8);
    chk("mk_irq_after_im", {31'd0, irq}, 32'd0);
    tick();
    chk("mk_irq_later", {31'd0, irq}, 32'd0);

    // pause at COUNT=7, PRESET write during CNT
    bus_write(A_PRE, 32'd9);
    bus_write(A_CTRL, 32'h9);
    tick(); tick();
    bus_read(A_CNT, rd); chk("pa_e2_cnt", rd, 32'd9);
    bus_write(A_PRE, 32'h55);
    bus_read(A_CNT, rd); chk("pa_pre_wr_cnt", rd, 32'd8);
    bus_write(A_CTRL, 32'h8);
    bus_read(A_CNT, rd); chk("pa_frz_cnt", rd, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    bus_read(A_CNT, rd); chk("pa_hold_cnt", rd, 32'd7);
    bus_read(A_PRE, rd); chk("pa_pre", rd, 32'h55);
    chk("pa_state", {30'd0, dbg_state}, 32'd0);

    // PRESET=0: INT at E3, reload discards frozen count
    bus_write(A_PRE, 32'd0);
    bus_write(A_CTRL, 32'h9);
    tick(); tick();
    bus_read(A_CNT, rd); chk("z_e2_cnt", rd, 32'd0);
    chk("z_e2_state", {30'd0, dbg_state}, 32'd2);
    chk("z_e2_irq", {31'd0, irq}, 32'd0);
    tick();
    chk("z_e3_state", {30'd0, dbg_state}, 32'd3);
    chk("z_e3_irq", {31'd0, irq}, 32'd1);
    tick();
    bus_write(A_CTRL, 32'h0);

    // address decode
    bus_write(A_PRE, 32'h1234);
    bus_write(BASE + 32'h10, 32'hDEAD);
    bus_write(A_CNT, 32'hDEAD);
    bus_write(A_RSV, 32'hDEAD);
    bus_write(32'h0000_0F04, 32'hBEEF);
    bus_write(A_CTRL, 32'hFFFF_FFF0);
    bus_read(A_CTRL, rd); chk("ad_ctrl", rd, 32'h0);
    bus_read(A_PRE, rd);  chk("ad_pre", rd, 32'h1234);
    bus_read(A_CNT, rd);  chk("ad_cnt", rd, 32'd0);
    bus_read(A_RSV, rd);  chk("ad_rsv", rd, 32'd0);
    bus_read(32'h0000_0004, rd); chk("ad_unsel_rd", rd, 32'h1234);
    chk("ad_state", {30'd0, dbg_state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
